// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-memory completer.
//   state_t     : transfer FSM states (IDLE, ACCESS)
//   APB_DATA_W  : APB data bus width
//   APB_LANES   : byte lanes per data word
//   word_index  : byte address -> word index
//   addr_ok     : word-aligned and inside a memory of 'depth' words
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int APB_DATA_W = 32;
  localparam int APB_LANES  = 4;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ((addr >> 2) < depth);
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 32-bit word memory with one shared word index.
// Synchronous byte-enabled write, asynchronous read, cleared by preset.
// Ports:
//   pclk, preset : clock and synchronous active-high reset
//   we, be       : write enable and per-byte lane enables
//   idx          : word index (out-of-range reads return 0, writes are dropped)
//   wdata, rdata : write and read data
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  we,
  input  logic [APB_LANES-1:0]  be,
  input  logic [31:0]           idx,
  input  logic [APB_DATA_W-1:0] wdata,
  output logic [APB_DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [APB_DATA_W-1:0] mem [DEPTH];
  logic                  in_range;
  logic [IDX_W-1:0]      widx;

  assign in_range = (idx < 32'(DEPTH));
  assign widx     = idx[IDX_W-1:0];

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      for (int b = 0; b < APB_LANES; b++) begin
        if (be[b]) begin
          mem[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (in_range) begin
      rdata = mem[widx];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer holding a small word-addressed register memory.
// A setup cycle latches the request; the access phase then holds pready low
// for WAIT_STATES cycles before completing. Misaligned or out-of-range
// addresses complete with pslverr=1 and no write.
// Optional feature: define APB_PSTRB_EN to add the pstrb port (byte-lane
// write strobes; a read with nonzero pstrb completes with pslverr=1).
// Ports:
//   pclk, preset           : clock, synchronous active-high reset
//   psel, penable, pwrite  : APB control
//   paddr, pwdata, [pstrb] : APB request address/data/strobes
//   prdata, pready, pslverr: APB response (prdata/pslverr are 0 unless pready)
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
`ifdef APB_PSTRB_EN
  input  logic [APB_LANES-1:0]  pstrb,
`endif
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  latch;

  // Setup-phase request registers
  logic [ADDR_W-1:0]     addr_p0;
  logic [APB_DATA_W-1:0] wdata_p0;
  logic                  write_p0;
`ifdef APB_PSTRB_EN
  logic [APB_LANES-1:0]  strb_p0;
`endif

  logic [31:0]           addr_ext;
  logic [31:0]           idx;
  logic                  err;
  logic                  we;
  logic [APB_LANES-1:0]  be;
  logic [APB_DATA_W-1:0] rdata;

  // Next-state logic. A setup cycle seen while already in ACCESS restarts
  // the transfer with the new request.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          latch   = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_n = IDLE;
        end else if (!penable) begin
          latch = 1'b1;
        end else if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (latch) begin
      cnt_n = 4'(WAIT_STATES);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      write_p0 <= 1'b0;
`ifdef APB_PSTRB_EN
      strb_p0  <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        addr_p0  <= paddr;
        wdata_p0 <= pwdata;
        write_p0 <= pwrite;
`ifdef APB_PSTRB_EN
        strb_p0  <= pstrb;
`endif
      end
    end
  end

  // Access phase: decode the latched request and form the response
  assign addr_ext = 32'(addr_p0);
  assign idx      = word_index(addr_ext);

`ifdef APB_PSTRB_EN
  assign err = !addr_ok(addr_ext, DEPTH) || (!write_p0 && (strb_p0 != '0));
  assign be  = strb_p0;
`else
  assign err = !addr_ok(addr_ext, DEPTH);
  assign be  = '1;
`endif

  assign pready  = (state == ACCESS) && psel && penable && (cnt == 4'd0);
  assign pslverr = pready && err;
  assign prdata  = (pready && !err && !write_p0) ? rdata : '0;
  assign we      = pready && write_p0 && !err;

  apb_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .we     (we),
    .be     (be),
    .idx    (idx),
    .wdata  (wdata_p0),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

  localparam int DEPTH = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [11:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb_v [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  logic [31:0] ref_mem [2][DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDR_W(12), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb_v[0]),
`endif
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

  apb_slave_mem #(.ADDR_W(12), .DEPTH(DEPTH), .WAIT_STATES(3)) dut1 (
    .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_PSTRB_EN
    .pstrb(pstrb_v[1]),
`endif
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Reference model: memory as plain arrays, errors from the address rules.
  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = 32'h0;
  endtask

  task automatic model_xfer(input int k, input logic wr, input logic [11:0] addr,
                            input logic [31:0] wd, input logic [3:0] strb,
                            output logic [31:0] erd, output logic eer);
    int idx;
    logic [3:0] mask;
    idx = int'(addr) / 4;
    eer = ((int'(addr) % 4) != 0) || (idx >= DEPTH);
`ifdef APB_PSTRB_EN
    mask = strb;
    if (!wr && strb != 4'h0) eer = 1'b1;
`else
    mask = 4'hF | strb;
`endif
    erd = 32'h0;
    if (!eer) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) ref_mem[k][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        erd = ref_mem[k][idx];
      end
    end
  endtask

  task automatic go_idle(input int k);
    @(negedge pclk);
    psel[k] = 1'b0;
    penable[k] = 1'b0;
  endtask

  // Drives one complete APB transfer and reports what the DUT returned.
  task automatic xfer(input int k, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb,
                      output logic [31:0] rd, output logic er, output int nw,
                      output int bad_wait, output logic tmo);
    @(negedge pclk);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
    paddr[k] = addr; pwdata[k] = wd; pstrb_v[k] = strb;
    @(negedge pclk);
    penable[k] = 1'b1;
    nw = 0; bad_wait = 0; tmo = 1'b1; rd = 32'h0; er = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (pready[k] === 1'b1) begin
        rd = prdata[k]; er = pslverr[k]; tmo = 1'b0;
        break;
      end
      if (prdata[k] !== 32'h0 || pslverr[k] !== 1'b0) bad_wait++;
      nw++;
      @(negedge pclk);
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(negedge pclk);
    for (int k = 0; k < 2; k++) begin psel[k] = 1'b1; penable[k] = 1'b1; end
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (pready[k] !== 1'b0) begin n_bad++; $display("FAIL reset_pready[%0d]: got %b want 0", k, pready[k]); end
      n_cmp++; if (pslverr[k] !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr[%0d]: got %b want 0", k, pslverr[k]); end
      n_cmp++; if (prdata[k] !== 32'h0) begin n_bad++; $display("FAIL reset_prdata[%0d]: got %h want 0", k, prdata[k]); end
    end
    @(negedge pclk);
    preset = 1'b0;
    for (int k = 0; k < 2; k++) begin psel[k] = 1'b0; penable[k] = 1'b0; end
    model_clear();
  endtask

  task automatic test_no_setup();
    @(negedge pclk);
    for (int k = 0; k < 2; k++) begin psel[k] = 1'b1; penable[k] = 1'b1; paddr[k] = 12'h0; end
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (pready[k] !== 1'b0) begin n_bad++; $display("FAIL no_setup_pready[%0d]: got %b want 0", k, pready[k]); end
      end
      @(negedge pclk);
    end
    for (int k = 0; k < 2; k++) begin psel[k] = 1'b0; penable[k] = 1'b0; end
  endtask

  task automatic test_read_write();
    logic [31:0] rd, erd; logic er, eer, tmo; int nw, bw;
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    model_xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, erd, eer);
    n_cmp++; if (tmo || nw != 0) begin n_bad++; $display("FAIL rd_after_reset_wait: got %0d want 0 (timeout %b)", nw, tmo); end
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL rd_after_reset: got %h/%b want 0/0", rd, er); end
    xfer(0, 1'b1, 12'h00C, 32'hDEADBEEF, 4'hF, rd, er, nw, bw, tmo);
    model_xfer(0, 1'b1, 12'h00C, 32'hDEADBEEF, 4'hF, erd, eer);
    n_cmp++; if (tmo || nw != 0 || er !== 1'b0) begin n_bad++; $display("FAIL wr_deadbeef: got wait %0d err %b want 0/0", nw, er); end
    xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    model_xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, erd, eer);
    n_cmp++; if (tmo || nw != 0 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_deadbeef: got %h err %b wait %0d want deadbeef/0/0", rd, er, nw); end
    go_idle(0);
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, erd; logic er, eer, tmo; int nw, bw;
    xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    n_cmp++; if (tmo || nw != 3 || rd !== 32'h0) begin n_bad++; $display("FAIL ws_read_old: got %h wait %0d want 0/3", rd, nw); end
    xfer(1, 1'b1, 12'h004, 32'h12345678, 4'hF, rd, er, nw, bw, tmo);
    model_xfer(1, 1'b1, 12'h004, 32'h12345678, 4'hF, erd, eer);
    n_cmp++; if (tmo || nw != 3 || bw != 0 || er !== 1'b0) begin n_bad++; $display("FAIL ws_write: got wait %0d bad %0d err %b want 3/0/0", nw, bw, er); end
    xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    n_cmp++; if (tmo || rd !== 32'h12345678) begin n_bad++; $display("FAIL ws_read_new: got %h want 12345678", rd); end
    go_idle(1);
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer, tmo; int nw, bw;
    xfer(0, 1'b0, 12'h040, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    n_cmp++; if (tmo || er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_range: got %h/%b want 0/1", rd, er); end
    xfer(0, 1'b1, 12'h002, 32'h00000001, 4'hF, rd, er, nw, bw, tmo);
    n_cmp++; if (tmo || er !== 1'b1) begin n_bad++; $display("FAIL err_misaligned: got %b want 1", er); end
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    model_xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, erd, eer);
    n_cmp++; if (tmo || er !== 1'b0 || rd !== erd) begin n_bad++; $display("FAIL err_no_write: got %h want %h", rd, erd); end
    go_idle(0);
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd, erd; logic er, eer, tmo; int nw, bw;
    xfer(1, 1'b1, 12'h010, 32'h0BADF00D, 4'hF, rd, er, nw, bw, tmo);
    model_xfer(1, 1'b1, 12'h010, 32'h0BADF00D, 4'hF, erd, eer);
    go_idle(1);
    // Abort by dropping psel in the second access cycle
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h010; pwdata[1] = 32'hAAAA5555;
    @(negedge pclk); penable[1] = 1'b1;
    @(negedge pclk); psel[1] = 1'b0; penable[1] = 1'b0;
    #1;
    n_cmp++; if (pready[1] !== 1'b0) begin n_bad++; $display("FAIL abort_pready: got %b want 0", pready[1]); end
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    n_cmp++; if (tmo || rd !== 32'h0BADF00D) begin n_bad++; $display("FAIL abort_readback: got %h want 0badf00d", rd); end
    go_idle(1);
    // Reset lands on the completing edge of a write
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h010; pwdata[1] = 32'hAAAA5555;
    @(negedge pclk); penable[1] = 1'b1;
    repeat (3) @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    model_clear();
    xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    n_cmp++; if (tmo || rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL reset_abort_readback: got %h/%b want 0/0", rd, er); end
    go_idle(1);
  endtask

  task automatic test_relatch();
    logic [31:0] rd, erd; logic er, eer, tmo; int nw, bw;
    @(negedge pclk);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h020; pwdata[1] = 32'h00000055;
    @(negedge pclk); penable[1] = 1'b1;
    // xfer issues a fresh setup cycle while the DUT is still in its access phase
    xfer(1, 1'b1, 12'h024, 32'h00000066, 4'hF, rd, er, nw, bw, tmo);
    model_xfer(1, 1'b1, 12'h024, 32'h00000066, 4'hF, erd, eer);
    n_cmp++; if (tmo || nw != 3) begin n_bad++; $display("FAIL relatch_wait: got %0d want 3", nw); end
    xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    n_cmp++; if (rd !== ref_mem[1][8]) begin n_bad++; $display("FAIL relatch_old_addr: got %h want %h", rd, ref_mem[1][8]); end
    xfer(1, 1'b0, 12'h024, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    n_cmp++; if (rd !== 32'h00000066) begin n_bad++; $display("FAIL relatch_new_addr: got %h want 00000066", rd); end
    go_idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd, wd; logic er, eer, tmo, wr; int nw, bw;
    logic [11:0] addr; logic [3:0] strb;
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 40; t++) begin
        wr = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) addr = 12'($urandom);
        else addr = 12'($urandom_range(0, 17) * 4);
        wd = $urandom;
        strb = 4'($urandom);
        if (!wr && $urandom_range(0, 5) != 0) strb = 4'h0;
        xfer(k, wr, addr, wd, strb, rd, er, nw, bw, tmo);
        model_xfer(k, wr, addr, wd, strb, erd, eer);
        n_cmp++;
        if (tmo || nw != ws(k) || bw != 0 || er !== eer || (!wr && rd !== erd)) begin
          n_bad++;
          $display("FAIL b2b[%0d.%0d] %s %h: got data %h err %b wait %0d want data %h err %b wait %0d",
                   k, t, wr ? "wr" : "rd", addr, rd, er, nw, erd, eer, ws(k));
        end
      end
      go_idle(k);
    end
  endtask

`ifdef APB_PSTRB_EN
  task automatic test_strobe();
    logic [31:0] rd, erd; logic er, eer, tmo; int nw, bw;
    xfer(0, 1'b1, 12'h000, 32'h11223344, 4'hF, rd, er, nw, bw, tmo);
    model_xfer(0, 1'b1, 12'h000, 32'h11223344, 4'hF, erd, eer);
    xfer(0, 1'b1, 12'h000, 32'hAABBCCDD, 4'b0101, rd, er, nw, bw, tmo);
    model_xfer(0, 1'b1, 12'h000, 32'hAABBCCDD, 4'b0101, erd, eer);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd, er, nw, bw, tmo);
    n_cmp++; if (tmo || rd !== 32'h11BB33DD || er !== 1'b0) begin n_bad++; $display("FAIL strobe_merge: got %h want 11bb33dd", rd); end
    xfer(0, 1'b0, 12'h000, 32'h0, 4'b0001, rd, er, nw, bw, tmo);
    n_cmp++; if (tmo || er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL strobe_read_err: got %h/%b want 0/1", rd, er); end
    go_idle(0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = 12'h0; pwdata[k] = 32'h0; pstrb_v[k] = 4'h0;
    end
    model_clear();
    test_reset();
    test_no_setup();
    test_read_write();
    test_wait_states();
    test_errors();
    test_abort_reset();
    test_relatch();
    test_back_to_back();
`ifdef APB_PSTRB_EN
    test_strobe();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
